// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Constants and types shared by the MIPS pipeline sequencing
//                logic: forwarding-select encodings, hazard FSM states,
//                shadow-slot records and the opcodes the decoder relies on.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // EX operand source selects
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // Opcodes shared with the decoder so both agree on what a load/store is
   localparam logic [5:0] LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011;

   // Hazard sequencer states
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } hc_state_e;

   // Everything the hazard logic needs to know about the instruction in EX
   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic [4:0] dst;
      logic       regwrite;
      logic       memread;
   } ex_slot_t;

   // Producer view of an instruction in MEM or WB
   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       regwrite;
   } wb_slot_t;

   // Reduce an EX record to the producer fields kept once it leaves EX
   function automatic wb_slot_t retire_slot(input ex_slot_t s);
      wb_slot_t r;
      r.valid    = s.valid;
      r.dst      = s.dst;
      r.regwrite = s.regwrite;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : hazard_ctrl_if
//  Description : ID-stage hazard information, branch/hold controls and the
//                resulting pipeline enables, forwarding selects and
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [4:0]       id_dst;
   logic             id_regwrite;
   logic             id_memread;
   logic             br_taken;
   logic             ext_hold;

   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Pipeline side: supplies the ID instruction, consumes the controls
   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
             id_regwrite, id_memread, br_taken, ext_hold,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b,
             stall_cnt, flush_cnt
   );

   // Hazard controller side
   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
             id_regwrite, id_memread, br_taken, ext_hold,
      output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b,
             stall_cnt, flush_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit
//  Description : Forwarding compare for one EX source operand. The younger
//                producer (MEM) wins over the older one (WB); register 0 is
//                hard-wired to zero and never forwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
   import cpu_pkg::*;
(
   input  logic [4:0] ex_src_i,
   input  logic       ex_use_i,
   input  wb_slot_t   mem_i,
   input  wb_slot_t   wb_i,
   output logic [1:0] sel_o
);

   logic mem_hit;
   logic wb_hit;

   // A producer hits when it writes the register this operand reads
   always_comb begin
      mem_hit = mem_i.valid && mem_i.regwrite && (mem_i.dst == ex_src_i);
      wb_hit  = wb_i.valid  && wb_i.regwrite  && (wb_i.dst  == ex_src_i);
   end

   // Pick the youngest matching producer, otherwise the register file
   always_comb begin
      sel_o = FWD_RF;
      if (ex_use_i && (ex_src_i != 5'd0)) begin
         if (mem_hit) begin
            sel_o = FWD_EXMEM;
         end else if (wb_hit) begin
            sel_o = FWD_MEMWB;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencing controller for the 5-stage MIPS core.
//                Shadows the destination of every in-flight instruction,
//                drives EX forwarding selects, inserts load-use bubbles,
//                flushes after taken branches, freezes on memory hold and
//                keeps saturating stall/flush cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic         CLK,
   input  logic         RST_N,
   hazard_ctrl_if.slave hc
);

   // Remaining-flush counter reload; the taken-branch cycle is itself the
   // first flush cycle, so only FLUSH_CYCLES-1 more follow.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   hc_state_e        state_q, state_d;
   logic [2:0]       fcnt_q, fcnt_d;
   ex_slot_t         ex_q, ex_d;
   wb_slot_t         mem_q, mem_d;
   wb_slot_t         wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   ex_slot_t         id_slot;
   logic             lu;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             stall_inc;
   logic             flush_inc;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;

   // Capture the ID instruction in slot form
   always_comb begin
      id_slot          = '0;
      id_slot.valid    = hc.id_valid;
      id_slot.rs       = hc.id_rs;
      id_slot.rt       = hc.id_rt;
      id_slot.use_rs   = hc.id_use_rs;
      id_slot.use_rt   = hc.id_use_rt;
      id_slot.dst      = hc.id_dst;
      id_slot.regwrite = hc.id_regwrite;
      id_slot.memread  = hc.id_memread;
   end

   // Load-use: a load in EX whose result the ID instruction reads
   always_comb begin
      lu = ex_q.valid && ex_q.memread && (ex_q.dst != 5'd0) && hc.id_valid &&
           ((hc.id_use_rs && (hc.id_rs == ex_q.dst)) ||
            (hc.id_use_rt && (hc.id_rt == ex_q.dst)));
   end

   fwd_unit u_fwd_a (
      .ex_src_i (ex_q.rs),
      .ex_use_i (ex_q.use_rs),
      .mem_i    (mem_q),
      .wb_i     (wb_q),
      .sel_o    (fwd_a)
   );

   fwd_unit u_fwd_b (
      .ex_src_i (ex_q.rt),
      .ex_use_i (ex_q.use_rt),
      .mem_i    (mem_q),
      .wb_i     (wb_q),
      .sel_o    (fwd_b)
   );

   // Sequencer: next state and pipeline controls, priority hold > branch > lu
   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      if (!RST_N) begin
         // While reset is held the controls sit at their idle values
         state_d = RUN;
      end else if (hc.ext_hold) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (hc.br_taken) begin
                  // Any concurrent load-use is moot: its consumer is squashed
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  flush_inc   = 1'b1;
                  fcnt_d      = FLUSH_LOAD;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                  end
               end else if (lu) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_bubble = 1'b1;
                  stall_inc   = 1'b1;
               end
            end
            FLUSH: begin
               // EX only ever holds a bubble here, so br_taken is ignored
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               flush_inc   = 1'b1;
               fcnt_d      = fcnt_q - 3'd1;
               if (fcnt_q <= 3'd1) begin
                  fcnt_d  = 3'd0;
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               fcnt_d  = 3'd0;
            end
         endcase
      end
   end

   // Sequencer state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= RUN;
         fcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Shadow slots advance with the pipeline and freeze on hold
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!hc.ext_hold) begin
         wb_d  = mem_q;
         mem_d = retire_slot(ex_q);
         ex_d  = (idex_bubble || !hc.id_valid) ? '0 : id_slot;
      end
   end

   // Shadow slot registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // Saturating increments: stop at all-ones rather than wrapping
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // Performance counter registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hc.pc_en       = pc_en;
   assign hc.ifid_en     = ifid_en;
   assign hc.ifid_flush  = ifid_flush;
   assign hc.idex_bubble = idex_bubble;
   assign hc.fwd_a       = fwd_a;
   assign hc.fwd_b       = fwd_b;
   assign hc.stall_cnt   = stall_cnt_q;
   assign hc.flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the ID/EX, EX/MEM and MEM/WB registers.
- Tracks the destination register of every in-flight instruction in its own EX/MEM/WB shadow slots.
- Generates the EX-stage operand forwarding selects, inserts load-use stall bubbles, flushes after a taken branch, and freezes on external memory hold.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- FLUSH_CYCLES, 1, number of cycles idex_bubble and ifid_flush stay asserted after a taken branch (1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt (not for I-type writing rt).
- id_dst  in  5  destination register (already regdist-muxed).
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is lw.
- br_taken  in  1  instruction now in EX is a branch whose flag[0] is set.
- ext_hold  in  1  memory not ready; whole pipeline freezes.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX instead of the ID instruction.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding, applied before the alusrc mux.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Reset (async, RST_N=0):
  - All shadow slots become invalid; FSM goes to RUN; flush counter is 0; stall_cnt and flush_cnt are 0.
  - Outputs are pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00.
  - A reset asserted mid-stall or mid-flush abandons that stall or flush immediately.
- Shadow slots:
  - EX slot holds {valid, rs, rt, use_rs, use_rt, dst, regwrite, memread}. MEM and WB slots hold {valid, dst, regwrite}.
  - Each CLK edge with ext_hold=0: WB<=MEM, MEM<=EX, EX<=ID fields, or an invalid slot when idex_bubble=1 or id_valid=0.
  - With ext_hold=1 every slot holds its value.
- Forwarding (combinational from the slots):
  - fwd_a=01 if MEM.valid & MEM.regwrite & MEM.dst!=0 & MEM.dst==EX.rs & EX.use_rs.
  - Otherwise fwd_a=10 under the same test against WB.
  - Otherwise fwd_a=00.
  - MEM has priority over WB. fwd_b is identical using EX.rt and EX.use_rt. Register 0 never forwards.
- Load-use condition (lu): EX.valid & EX.memread & EX.dst!=0 & id_valid & ((id_use_rs & id_rs==EX.dst) | (id_use_rt & id_rt==EX.dst)).
- FSM states: RUN, FLUSH. Priority per cycle is ext_hold > br_taken > lu.
  - RUN with ext_hold=1: pc_en=0, ifid_en=0, idex_bubble=0; no state change; counters hold.
  - RUN with br_taken=1: ifid_flush=1, idex_bubble=1, pc_en=1; flush counter loads FLUSH_CYCLES-1; flush_cnt+1. Go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
    - A coincident lu is ignored, because the dependent instruction is squashed.
  - RUN with lu=1: pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt+1.
    - The stall lasts exactly 1 cycle, because the lw moves to MEM and the condition drops; the loaded value is then forwarded from WB a cycle later.
  - FLUSH: ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt+1; counter decrements; return to RUN when the counter is 0.
    - ext_hold=1 in FLUSH freezes the counter, and all outputs follow the RUN ext_hold rule.
    - br_taken is ignored in FLUSH, because EX then holds a bubble.
- Counters saturate at all-ones and never wrap.
- No output has latency: all outputs are combinational from state and inputs in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The state enum {RUN, FLUSH}.
  - The opcode constants LW=6'b100011 and SW=6'b101011, so the decoder and this block agree.
- One natural sub-module, fwd_unit: the pure combinational forwarding compare, instantiated twice (operands A and B).

Test Plan:
- Back-to-back dependence: add $3,$1,$2 then sub $4,$3,$5. When sub is in EX, fwd_a=01; one cycle later with a filler instruction, a dependent instruction sees fwd_a=10. No stall occurs.
- Load-use: lw $8,0($1) then add $9,$8,$2. Exactly one cycle of pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt=1. Next cycle, add in EX has fwd_a=10.
- Register 0: addu $0,$1,$2 then or $5,$0,$6 gives fwd_a=00. lw $0 followed by a user of $0 gives no stall.
- Taken branch with FLUSH_CYCLES=2: br_taken pulses for 1 cycle. ifid_flush and idex_bubble stay high for 2 cycles with pc_en=1; flush_cnt=2. A concurrent lu gives stall_cnt unchanged.
- Hold during flush: ext_hold=1 for 3 cycles in the second FLUSH cycle. Outputs follow the hold rule, flush resumes afterwards, and the total is flush_cnt=2. Slots are unchanged across the hold.
- Reset mid-stall: drop RST_N during lu. Outputs go to reset values asynchronously, and all counters read 0.
